// File: rtl/mem_initiator.sv
// mem_initiator
//   Bus initiator that arbitrates an instruction-fetch port and a data port
//   onto one single-port memory. One transaction is in flight at a time; the
//   response is returned to the port that issued it. A watchdog completes a
//   transaction with zero data and a sticky error if the memory never answers.
//
// Parameters
//   timeout     number of cycles after issue in which mem_ready is accepted
//               (1..65535)
//
// Ports
//   clock       rising-edge clock
//   reset       synchronous active-high reset
//   imem_*      fetch requester: valid/addr in, rdata/ready out
//   dmem_*      data requester: valid/addr/wdata/wstrb in, rdata/ready out
//   mem_*       memory side: valid/instr/addr/wdata/wstrb out, rdata/ready in
//   mem_error   sticky watchdog-expiry flag, cleared only by reset
module mem_initiator #(
  parameter int unsigned timeout = 255
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,

  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,

  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_error
);

  localparam logic [15:0] TimeoutW = 16'(timeout);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic        last_instr_q, last_instr_d;   // 1: fetch was served last

  logic        mem_valid_d, mem_instr_d, mem_error_d;
  logic [31:0] mem_addr_d, mem_wdata_d;
  logic [3:0]  mem_wstrb_d;
  logic        imem_ready_d, dmem_ready_d;
  logic [31:0] imem_rdata_d, dmem_rdata_d;
  logic [31:0] resp_data;
  logic        pick_instr;

  // Fetch wins when it is alone, or on a tie when data was served last.
  assign pick_instr = imem_valid && (!dmem_valid || !last_instr_q);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      last_instr_q <= 1'b1;
      mem_valid    <= 1'b0;
      mem_instr    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
      mem_error    <= 1'b0;
      imem_ready   <= 1'b0;
      dmem_ready   <= 1'b0;
      imem_rdata   <= '0;
      dmem_rdata   <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      last_instr_q <= last_instr_d;
      mem_valid    <= mem_valid_d;
      mem_instr    <= mem_instr_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      mem_wstrb    <= mem_wstrb_d;
      mem_error    <= mem_error_d;
      imem_ready   <= imem_ready_d;
      dmem_ready   <= dmem_ready_d;
      imem_rdata   <= imem_rdata_d;
      dmem_rdata   <= dmem_rdata_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    count_d      = count_q;
    last_instr_d = last_instr_q;
    mem_valid_d  = 1'b0;
    mem_instr_d  = mem_instr;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    mem_wstrb_d  = mem_wstrb;
    mem_error_d  = mem_error;
    imem_ready_d = 1'b0;
    dmem_ready_d = 1'b0;
    imem_rdata_d = imem_rdata;
    dmem_rdata_d = dmem_rdata;
    resp_data    = '0;

    unique case (state_q)
      IDLE: begin
        if (imem_valid || dmem_valid) begin
          state_d     = BUSY;
          count_d     = '0;
          mem_valid_d = 1'b1;
          mem_instr_d = pick_instr;
          if (pick_instr) begin
            mem_addr_d  = imem_addr;
            mem_wdata_d = '0;
            mem_wstrb_d = '0;
          end else begin
            mem_addr_d  = dmem_addr;
            mem_wdata_d = dmem_wdata;
            mem_wstrb_d = dmem_wstrb;
          end
        end
      end

      BUSY: begin
        // The issue cycle (mem_valid high) never accepts a response. The count
        // therefore equals the number of accept-window cycles already begun,
        // and the last accepted cycle is the one where it equals timeout.
        if (mem_valid) begin
          count_d = count_q + 16'd1;
        end else if (mem_ready || count_q == TimeoutW) begin
          state_d   = RESP;
          resp_data = mem_ready ? mem_rdata : '0;
          if (!mem_ready) begin
            mem_error_d = 1'b1;
          end
          if (mem_instr) begin
            imem_ready_d = 1'b1;
            imem_rdata_d = resp_data;
          end else begin
            dmem_ready_d = 1'b1;
            dmem_rdata_d = resp_data;
          end
        end else begin
          count_d = count_q + 16'd1;
        end
      end

      RESP: begin
        // Requesters still hold valid in this cycle, so no arbitration here.
        state_d      = IDLE;
        last_instr_d = mem_instr;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/mem_initiator.md
# mem_initiator

Bus initiator for the single-port memory protocol used by the on-chip block RAM (valid / instr / addr / wdata / wstrb out; rdata / ready back). It sits between the core's instruction-fetch and data ports and one memory port. It arbitrates the two requesters, issues one transaction at a time and returns each response to the port that requested it. A watchdog completes a transaction with an error if the memory never answers.

## Interface

Parameters:
- `timeout`, default 255: number of cycles after issue during which `mem_ready` is accepted. Legal range is 1..65535.

Ports:
- `clock` in 1: the only clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `imem_valid` in 1: fetch request, level. Address must be held stable until `imem_ready`.
- `imem_addr` in 32: fetch address.
- `imem_rdata` out 32: fetch data. Valid only while `imem_ready` = 1.
- `imem_ready` out 1: one-cycle completion pulse for the fetch port.
- `dmem_valid` in 1: data request, level. Fields must be held stable until `dmem_ready`.
- `dmem_addr` in 32: data address.
- `dmem_wdata` in 32: write data.
- `dmem_wstrb` in 4: byte enables. 0 means read.
- `dmem_rdata` out 32: data read result. Valid only while `dmem_ready` = 1.
- `dmem_ready` out 1: one-cycle completion pulse for the data port.
- `mem_valid` out 1: request strobe. Exactly one cycle per transaction.
- `mem_instr` out 1: 1 for a fetch, 0 for a data access.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_wstrb` out 4: memory byte enables.
- `mem_rdata` in 32: memory read data. Sampled only when `mem_ready` = 1.
- `mem_ready` in 1: memory response.
- `mem_error` out 1: sticky flag, set on watchdog expiry.

## Operation

States:
- IDLE: waiting for a request.
- BUSY: transaction issued, waiting for `mem_ready`.
- RESP: one cycle that drives the requester's ready pulse.

IDLE:
- Neither valid: stay in IDLE.
- One valid: grant that port.
- Both valid: grant the port not served last (round-robin). The `last` register resets to "instr", so data wins the first tie.
- On grant, the next cycle drives:
  - `mem_valid` = 1;
  - `mem_addr` = request address;
  - `mem_instr` = 1 for a fetch, 0 for data;
  - for data: `mem_wdata` and `mem_wstrb` from the data port;
  - for a fetch: `mem_wdata` = 0 and `mem_wstrb` = 0.
- Then go to BUSY.

BUSY:
- `mem_valid` = 0.
- `mem_addr`, `mem_instr`, `mem_wdata` and `mem_wstrb` hold their values.
- Watchdog counter (16 bit) clears at issue and increments each BUSY cycle without `mem_ready`.
- `mem_ready` = 1: capture `mem_rdata` into the granted port's rdata register and go to RESP.
- Counter reaches `timeout` with no `mem_ready`: capture 0, set `mem_error` and go to RESP.

RESP:
- Granted port's ready = 1 and rdata = captured value; update `last`.
- Both requester valids are ignored this cycle, because the requester still holds valid high in the cycle it sees ready.
- Go to IDLE.

Other rules:
- `mem_ready` in IDLE or RESP (late or unsolicited) is ignored and does not change `mem_error`.
- `mem_ready` in the issue cycle (the cycle with `mem_valid` = 1) is ignored. The memory responds no earlier than the following cycle.
- Writes also complete through RESP. The rdata register holds whatever `mem_rdata` showed and carries no meaning.
- `mem_error` clears only on `reset`.

## Timing

- Every output is a register.
- Reset values: all outputs 0, state IDLE, `last` = instr, counter 0.
- Reset asserted mid-transaction: state returns to IDLE. No ready pulse is produced for the aborted request. All outputs read 0 in the cycle after reset is sampled.
- A request seen in IDLE at cycle t produces:
  - `mem_valid` at t+1;
  - `mem_ready` accepted at t+2 .. t+1+`timeout`;
  - a response accepted at cycle r produces the port ready at r+1.
- Minimum latency against a one-cycle memory is 3 cycles: request at t, ready at t+3.
- Watchdog expiry produces the port ready at t+2+`timeout`.
- Back-to-back throughput with a one-cycle memory is one transaction per 4 cycles.
- Nothing is pipelined. A new issue can start no earlier than the cycle after RESP.

## Test plan

- **Data read:** memory word at 0x100 = 0xDEADBEEF; `dmem_valid` at cycle 0 with `dmem_wstrb` = 0.
  - Cycle 1: `mem_valid` = 1, `mem_instr` = 0, `mem_addr` = 0x100.
  - Cycle 3: `dmem_ready` = 1, `dmem_rdata` = 0xDEADBEEF.
  - `imem_ready` stays 0 throughout.
- **Fetch:** `imem_addr` = 0x80 with `dmem_wdata` = 0xFFFFFFFF and `dmem_wstrb` = 0xF present on the idle data port.
  - `mem_instr` = 1, `mem_wstrb` = 0, `mem_wdata` = 0.
  - `imem_ready` at cycle 3 with the memory word.
- **Partial write:** `dmem_wstrb` = 0x3, `dmem_wdata` = 0x12345678, address 0x200, word previously 0xAABBCCDD.
  - Memory sees `mem_wstrb` = 0011.
  - A following read of 0x200 returns 0xAABB5678.
- **Arbitration:** both valid, held continuously, starting after reset.
  - Grant order is D, I, D, I.
  - Each ready pulse lasts one cycle.
  - No transaction is issued twice.
- **Watchdog:** `timeout` = 4 and the memory never asserts `mem_ready`; `dmem_valid` at cycle 0.
  - `dmem_ready` at cycle 6 with `dmem_rdata` = 0; `mem_error` = 1 from then on.
  - A late `mem_ready` at cycle 7 is ignored.
  - `mem_error` stays 1 until reset.
- **Reset mid-op:** `reset` at cycle 2 of a data read.
  - All outputs read 0 at cycle 3 and no `dmem_ready` pulse is produced.
  - A new request after reset completes normally with 3-cycle latency.
